board_drop: RTL and testbench
=============================

BOARD_DROP -- requirements
Module: board_drop

Interface
REQ-001 The block SHALL have parameter ROWS, default 6, meaning the number of board rows; row 0 is the bottom row.
REQ-002 The block SHALL have parameter COLS, default 7, meaning the number of board columns.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port move_valid, input, 1 bit: a move request, sampled only in IDLE.
REQ-006 The block SHALL have port column, input, 3 bits: the target column, 0 to COLS-1.
REQ-007 The block SHALL have port player, input, 1 bit: the mover, where 0 is player 1 and 1 is player 2.
REQ-008 The block SHALL have port move_ready, output, 1 bit: high while in IDLE.
REQ-009 The block SHALL have port move_done, output, 1 bit: a one-cycle pulse when a piece has been placed; this pulse drives the turn-change stage.
REQ-010 The block SHALL have port move_rejected, output, 1 bit: a one-cycle pulse when a move is refused.
REQ-011 The block SHALL have port last_row, output, 3 bits: the row where the most recent piece landed.
REQ-012 The block SHALL have port board, output, 2*ROWS*COLS bits: the flattened cell array.
REQ-013 The block SHALL have port board_full, output, 1 bit: high when every cell is non-empty.

Function
REQ-014 Cell encoding SHALL be: 00 empty, 01 player 1, 10 player 2; 11 SHALL never be written.
REQ-015 Cell (r,c) SHALL occupy board bits [2*(r*COLS+c)+1 : 2*(r*COLS+c)].
REQ-016 The FSM SHALL have exactly four states: IDLE, SCAN, DONE, REJECT.
REQ-017 In IDLE with move_valid=1 and column<COLS, the block SHALL, at the next edge, latch column and player, clear the row counter to 0, and enter SCAN.
REQ-018 In IDLE with move_valid=1 and column>=COLS, the block SHALL enter REJECT at the next edge and leave the board unchanged.
REQ-019 In SCAN, each cycle the block SHALL examine cell (row, latched column):
  - empty: write the latched player code to that cell, load last_row with row, enter DONE;
  - occupied and row<ROWS-1: increment row, stay in SCAN;
  - occupied and row==ROWS-1: enter REJECT (column full), board unchanged.
REQ-020 DONE SHALL last exactly one cycle with move_done=1, then return to IDLE.
REQ-021 REJECT SHALL last exactly one cycle with move_rejected=1, then return to IDLE.
REQ-022 Latency: a move into a column holding k pieces (k<ROWS) SHALL assert move_done in cycle k+2 after the accepting edge (cycle 0); a full column SHALL assert move_rejected in cycle ROWS+1.
REQ-023 move_valid, column and player SHALL be ignored outside IDLE; the latched values SHALL be used throughout SCAN.
REQ-024 move_done and move_rejected SHALL never be high in the same cycle.
REQ-025 At most one cell SHALL change per move.
REQ-026 board_full SHALL be combinational from board; it SHALL NOT block moves, since full columns reject naturally.
REQ-027 last_row SHALL hold its value until the next successful placement.

Reset
REQ-028 On reset=1 at a clock edge, the block SHALL enter IDLE, clear all cells to 00, and set last_row=0, move_done=0 and move_rejected=0, from any state including mid-SCAN; no partial write SHALL survive.
REQ-029 After reset, move_ready SHALL be 1 and board_full SHALL be 0.

Verification
REQ-030 The bench SHALL check: after reset, move col 3 by player 0 -> move_done in cycle 2, cell (0,3)=01, last_row=0.
REQ-031 The bench SHALL check: 6 alternating moves into col 0 -> rows 0–5 hold 01,10,01,10,01,10, and the 6th move_done arrives in cycle 7.
REQ-032 The bench SHALL check: a 7th move into full col 0 -> move_rejected in cycle 7, board unchanged, no move_done.
REQ-033 The bench SHALL check: column=7 -> move_rejected in cycle 1, board unchanged.
REQ-034 The bench SHALL check: move_valid held high with changing column during SCAN -> only the first request takes effect.
REQ-035 The bench SHALL check: reset asserted mid-SCAN on a 3-deep column -> board all zero, IDLE next cycle; fill all 42 cells -> board_full=1.

Source files
------------

// File: rtl/board_drop.sv
// board_drop: drops a piece into a column of a ROWS x COLS board, scanning up from row 0
// for the first empty cell; reports placement, rejection, landing row and fullness.
module board_drop #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     move_valid,
    input  logic [2:0]               column,
    input  logic                     player,
    output logic                     move_ready,
    output logic                     move_done,
    output logic                     move_rejected,
    output logic [2:0]               last_row,
    output logic [2*ROWS*COLS-1:0]   board,
    output logic                     board_full
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE, REJECT} state_t;
    state_t     state;
    logic [2:0] col_q;
    logic       player_q;
    logic [2:0] row;
    int         idx;
    logic [1:0] cur;
    always_comb begin
        idx = int'(row) * COLS + int'(col_q);
        cur = board[2*idx +: 2];
    end
    always_comb begin
        board_full = 1'b1;
        for (int i = 0; i < ROWS*COLS; i++)
            board_full = board_full & (|board[2*i +: 2]);
    end
    assign move_ready = (state == IDLE);
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            board         <= '0;
            last_row      <= '0;
            move_done     <= 1'b0;
            move_rejected <= 1'b0;
            col_q         <= '0;
            player_q      <= 1'b0;
            row           <= '0;
        end else begin
            move_done     <= 1'b0;
            move_rejected <= 1'b0;
            case (state)
                IDLE: if (move_valid) begin
                    if (32'(column) < COLS) begin
                        col_q    <= column;
                        player_q <= player;
                        row      <= '0;
                        state    <= SCAN;
                    end else begin
                        move_rejected <= 1'b1;
                        state         <= REJECT;
                    end
                end
                SCAN: if (cur == 2'b00) begin
                    // player 0 -> 01, player 1 -> 10
                    board[2*idx +: 2] <= {player_q, ~player_q};
                    last_row          <= row;
                    move_done         <= 1'b1;
                    state             <= DONE;
                end else if (row == 3'(ROWS-1)) begin
                    move_rejected <= 1'b1;
                    state         <= REJECT;
                end else begin
                    row <= row + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_drop.sv
// tb_board_drop: random and directed moves checked against a column-height board model.
module tb_board_drop;
    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int W = 2*ROWS*COLS;
    logic clk = 0, reset = 1, move_valid = 0, player = 0;
    logic [2:0] column = 0;
    logic move_ready, move_done, move_rejected, board_full;
    logic [2:0] last_row;
    logic [W-1:0] board;
    int compared = 0, mismatched = 0;
    int heights[COLS];
    int cells[ROWS][COLS];
    int exp_last = 0;

    board_drop #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .reset(reset), .move_valid(move_valid), .column(column),
        .player(player), .move_ready(move_ready), .move_done(move_done),
        .move_rejected(move_rejected), .last_row(last_row), .board(board),
        .board_full(board_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < COLS; c++) begin
            heights[c] = 0;
            for (int r = 0; r < ROWS; r++) cells[r][c] = 0;
        end
        exp_last = 0;
    endtask

    function automatic logic [W-1:0] model_board();
        logic [W-1:0] b = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                b[2*(r*COLS+c) +: 2] = 2'(cells[r][c]);
        return b;
    endfunction

    function automatic bit model_full();
        for (int c = 0; c < COLS; c++) if (heights[c] < ROWS) return 0;
        return 1;
    endfunction

    task automatic do_move(input int c, input bit p, input bit hold);
        bit exp_done;
        int exp_cyc, got_cyc;
        bit got_done;
        if (c >= COLS) begin exp_done = 0; exp_cyc = 1; end
        else if (heights[c] == ROWS) begin exp_done = 0; exp_cyc = ROWS + 1; end
        else begin exp_done = 1; exp_cyc = heights[c] + 2; end
        check("ready_before", move_ready, 1);
        move_valid = 1; column = 3'(c); player = p;
        @(posedge clk); #1;
        if (!hold) move_valid = 0;
        got_cyc = 0; got_done = 0;
        for (int n = 1; n <= 20; n++) begin
            check("exclusive", move_done & move_rejected, 0);
            if (move_done || move_rejected) begin
                got_cyc = n; got_done = move_done;
                break;
            end
            if (hold) begin column = 3'($urandom_range(0, 7)); player = 1'($urandom); end
            @(posedge clk); #1;
        end
        move_valid = 0;
        check("pulse_cycle", got_cyc, exp_cyc);
        check("done_not_reject", got_done, exp_done);
        if (exp_done) begin
            cells[heights[c]][c] = p ? 2 : 1;
            exp_last = heights[c];
            heights[c]++;
        end
        @(posedge clk); #1;
        check("ready_after", move_ready, 1);
        check("pulse_gone", move_done | move_rejected, 0);
        check("board", board, model_board());
        check("last_row", last_row, exp_last);
        check("board_full", board_full, model_full());
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_board", board, 0);
        check("rst_last_row", last_row, 0);
        check("rst_pulses", {move_done, move_rejected}, 0);
        reset = 0;
        @(posedge clk); #1;
        check("rst_ready", move_ready, 1);
        check("rst_full", board_full, 0);
        do_move(3, 0, 0);
        check("cell_0_3", board[2*3 +: 2], 2'b01);
        for (int i = 0; i < ROWS; i++) do_move(0, 1'(i), 0);
        for (int r = 0; r < ROWS; r++)
            check("col0_row", board[2*(r*COLS) +: 2], (r % 2) ? 2'b10 : 2'b01);
        do_move(0, 1, 0);
        do_move(7, 0, 0);
        do_move(5, 1, 1);
        do_move(5, 0, 1);
        do_move(7, 1, 1);
        for (int i = 0; i < 30; i++) do_move($urandom_range(0, 7), 1'($urandom), 1'($urandom));
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_clear();
        for (int i = 0; i < 3; i++) do_move(2, 1'(i), 0);
        move_valid = 1; column = 3'd2; player = 1;
        @(posedge clk); #1;
        move_valid = 0;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_clear();
        check("midscan_board", board, 0);
        check("midscan_ready", move_ready, 1);
        check("midscan_pulses", {move_done, move_rejected}, 0);
        check("midscan_last_row", last_row, 0);
        @(posedge clk); #1;
        check("midscan_still_clear", board, 0);
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) do_move(c, 1'($urandom), 0);
        check("full_flag", board_full, 1);
        do_move($urandom_range(0, COLS-1), 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
